// File: rtl/atm_keypad_entry.sv
// Keypad front-end: turns serial key events into the ATM core's session levels.
// Optional PIN lockout after three failed authentications: define ATM_PIN_LOCKOUT_EN.
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int AUTH_WAIT      = 8,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_ok,
    output logic [11:0] accNumber,
    output logic [3:0]  pin,
    output logic [2:0]  menuOption,
    output logic [10:0] amount,
    output logic [11:0] destinationAcc,
    output logic        cmd_valid,
    output logic        entry_error,
    output logic        locked
);
    localparam logic [2:0] S_ACC = 3'd0, S_PIN = 3'd1, S_AUTH = 3'd2, S_MENU = 3'd3,
                           S_AMT = 3'd4, S_DEST = 3'd5, S_HOLD = 3'd6, S_LOCKED = 3'd7;
    localparam logic [3:0] K_CLEAR = 4'd10, K_ENTER = 4'd11, K_CANCEL = 4'd12;
    localparam logic [2:0] M_WAIT = 3'b000, M_MENU = 3'b010, OP_BAL = 3'd3, OP_XFER = 3'd6;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMAX = (AUTH_WAIT > HOLD_CYCLES) ? AUTH_WAIT : HOLD_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] AUTH_LAST = TW'(AUTH_WAIT - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    logic [2:0]    state_q, state_d, menu_q, menu_d, op_q, op_d, dig_q, dig_d;
    logic [11:0]   acc_q, acc_d, dest_q, dest_d;
    logic [3:0]    pin_q, pin_d;
    logic [10:0]   amt_q, amt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          cmd_q, cmd_d, err_q, err_d;
    logic [15:0]   cur_s, lim_s, nxt_s;
    logic [11:0]   fld_val_s;
    logic [2:0]    maxd_s;
    logic          dig_ok_s, timeout_s, logout_s, fld_we_s, go_hold_s, is_digit_s;
`ifdef ATM_PIN_LOCKOUT_EN
    logic [1:0]    fail_q, fail_d;
    logic          locked_q, locked_d;
`endif

    // Select the field being typed into, and decide whether the next digit fits it.
    always_comb begin
        case (state_q)
            S_ACC:   begin cur_s = {4'd0, acc_q};  lim_s = 16'd4095; maxd_s = 3'd4; end
            S_PIN:   begin cur_s = {12'd0, pin_q}; lim_s = 16'd9;    maxd_s = 3'd1; end
            S_AMT:   begin cur_s = {5'd0, amt_q};  lim_s = 16'd2047; maxd_s = 3'd4; end
            S_DEST:  begin cur_s = {4'd0, dest_q}; lim_s = 16'd4095; maxd_s = 3'd4; end
            default: begin cur_s = 16'd0;          lim_s = 16'd0;    maxd_s = 3'd0; end
        endcase
        nxt_s      = cur_s * 16'd10 + {12'd0, key_code};
        dig_ok_s   = (dig_q < maxd_s) && (nxt_s <= lim_s);
        is_digit_s = (key_code <= 4'd9);
    end

    // Idle counter and logout-on-inactivity; an empty account field never times out.
    always_comb begin
        timeout_s = 1'b0;
        idle_d    = idle_q;
        if (key_valid) begin
            idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
            if ((state_q != S_LOCKED) && !((state_q == S_ACC) && (dig_q == 3'd0))) begin
                timeout_s = 1'b1;
                idle_d    = '0;
            end else begin
                idle_d = idle_q;
            end
        end else begin
            idle_d = idle_q + IW'(1);
        end
        logout_s = timeout_s || (key_valid && (key_code == K_CANCEL) && (state_q != S_LOCKED));
    end

    // Session state machine and field updates.
    always_comb begin
        state_d = state_q; acc_d = acc_q; pin_d = pin_q; menu_d = menu_q;
        amt_d = amt_q; dest_d = dest_q; op_d = op_q; dig_d = dig_q; tmr_d = tmr_q;
        cmd_d = 1'b0; err_d = 1'b0; fld_we_s = 1'b0; fld_val_s = 12'd0; go_hold_s = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
        fail_d = fail_q; locked_d = locked_q;
`endif
        if (logout_s) begin
            state_d = S_ACC; acc_d = 12'd0; pin_d = 4'd0; menu_d = M_WAIT; amt_d = 11'd0;
            dest_d = 12'd0; op_d = 3'd0; dig_d = 3'd0; tmr_d = '0;
`ifdef ATM_PIN_LOCKOUT_EN
            fail_d = 2'd0;
`endif
        end else begin
            case (state_q)
                S_ACC, S_PIN, S_AMT, S_DEST: begin
                    if (!key_valid) begin
                        err_d = 1'b0;
                    end else if (is_digit_s) begin
                        if (dig_ok_s) begin
                            fld_we_s = 1'b1; fld_val_s = nxt_s[11:0]; dig_d = dig_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_code == K_CLEAR) begin
                        fld_we_s = 1'b1; dig_d = 3'd0;
                    end else if (key_code == K_ENTER) begin
                        if (dig_q == 3'd0) begin
                            err_d = 1'b1;
                        end else begin
                            dig_d = 3'd0; tmr_d = '0;
                            case (state_q)
                                S_ACC:   state_d = S_PIN;
                                S_PIN:   state_d = S_AUTH;
                                S_AMT:   if (op_q == OP_XFER) state_d = S_DEST; else go_hold_s = 1'b1;
                                default: go_hold_s = 1'b1;
                            endcase
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_AUTH: begin
                    if (auth_ok) begin
                        state_d = S_MENU; menu_d = M_MENU;
`ifdef ATM_PIN_LOCKOUT_EN
                        fail_d = 2'd0;
`endif
                    end else if (tmr_q == AUTH_LAST) begin
                        state_d = S_PIN; pin_d = 4'd0; dig_d = 3'd0; err_d = 1'b1;
`ifdef ATM_PIN_LOCKOUT_EN
                        if (fail_q == 2'd2) begin
                            state_d = S_LOCKED; locked_d = 1'b1; menu_d = M_WAIT;
                        end else begin
                            fail_d = fail_q + 2'd1;
                        end
`endif
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                S_MENU: begin
                    if (!key_valid) begin
                        err_d = 1'b0;
                    end else if (is_digit_s && (key_code >= 4'd3) && (key_code <= 4'd7)) begin
                        op_d = key_code[2:0]; amt_d = 11'd0; dest_d = 12'd0; dig_d = 3'd0;
                        if (key_code[2:0] == OP_BAL) go_hold_s = 1'b1; else state_d = S_AMT;
                    end else if (key_code == K_CLEAR) begin
                        amt_d = 11'd0; dest_d = 12'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_d = S_MENU; menu_d = M_MENU;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                S_LOCKED: state_d = S_LOCKED;
                default:  state_d = S_ACC;
            endcase
        end
        if (fld_we_s) begin
            case (state_q)
                S_ACC:   acc_d  = fld_val_s;
                S_PIN:   pin_d  = fld_val_s[3:0];
                S_AMT:   amt_d  = fld_val_s[10:0];
                S_DEST:  dest_d = fld_val_s;
                default: acc_d  = acc_q;
            endcase
        end else begin
            fld_val_s = 12'd0;
        end
        // Committing an operation publishes it and pulses cmd_valid in the same cycle.
        if (go_hold_s) begin
            state_d = S_HOLD; menu_d = op_d; cmd_d = 1'b1; tmr_d = '0;
        end else begin
            cmd_d = 1'b0;
        end
    end

    // Session registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ACC;  acc_q <= 12'd0; pin_q <= 4'd0;  menu_q <= M_WAIT;
            amt_q   <= 11'd0;  dest_q <= 12'd0; op_q <= 3'd0;  dig_q <= 3'd0;
            idle_q  <= '0;     tmr_q <= '0;     cmd_q <= 1'b0; err_q <= 1'b0;
        end else begin
            state_q <= state_d; acc_q <= acc_d; pin_q <= pin_d; menu_q <= menu_d;
            amt_q   <= amt_d;   dest_q <= dest_d; op_q <= op_d; dig_q <= dig_d;
            idle_q  <= idle_d;  tmr_q <= tmr_d;   cmd_q <= cmd_d; err_q <= err_d;
        end
    end

`ifdef ATM_PIN_LOCKOUT_EN
    // Consecutive-failure counter and lockout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= 2'd0; locked_q <= 1'b0;
        end else begin
            fail_q <= fail_d; locked_q <= locked_d;
        end
    end
    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    assign accNumber      = acc_q;
    assign pin            = pin_q;
    assign menuOption     = menu_q;
    assign amount         = amt_q;
    assign destinationAcc = dest_q;
    assign cmd_valid      = cmd_q;
    assign entry_error    = err_q;
endmodule

// File: tb/tb_atm_keypad_entry.sv
// Self-checking bench for atm_keypad_entry: directed vector table, corner sequences, random vs model.
module tb_atm_keypad_entry;
    localparam int TMO = 1000, AW = 8, HC = 4;

    logic        clk = 1'b0, rst = 1'b1, key_valid = 1'b0, auth_ok = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [11:0] accNumber, destinationAcc;
    logic [3:0]  pin;
    logic [2:0]  menuOption;
    logic [10:0] amount;
    logic        cmd_valid, entry_error, locked;
    int total = 0, bad = 0;

    atm_keypad_entry #(.TIMEOUT_CYCLES(TMO), .AUTH_WAIT(AW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .auth_ok(auth_ok),
        .accNumber(accNumber), .pin(pin), .menuOption(menuOption), .amount(amount),
        .destinationAcc(destinationAcc), .cmd_valid(cmd_valid), .entry_error(entry_error),
        .locked(locked));

    always #5 clk = ~clk;

    typedef struct {
        int kv, code, auth;
        int acc, pin, menu, amt, dest, cmd, err;
    } vec_t;
    vec_t tbl[$];

    function automatic void v(input int kv, input int code, input int auth, input int acc,
                              input int pn, input int menu, input int amt, input int dest,
                              input int cmd, input int err);
        vec_t r;
        r.kv = kv; r.code = code; r.auth = auth; r.acc = acc; r.pin = pn; r.menu = menu;
        r.amt = amt; r.dest = dest; r.cmd = cmd; r.err = err;
        tbl.push_back(r);
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void check_all(input string nm, input int acc, input int pn, input int menu,
                                      input int amt, input int dest, input int cmd, input int err);
        chk({nm, ".acc"}, int'(accNumber), acc);
        chk({nm, ".pin"}, int'(pin), pn);
        chk({nm, ".menu"}, int'(menuOption), menu);
        chk({nm, ".amt"}, int'(amount), amt);
        chk({nm, ".dest"}, int'(destinationAcc), dest);
        chk({nm, ".cmd"}, int'(cmd_valid), cmd);
        chk({nm, ".err"}, int'(entry_error), err);
    endfunction

    task automatic step(input int kv, input int code, input int auth);
        @(negedge clk);
        key_valid = (kv != 0); key_code = 4'(code); auth_ok = (auth != 0);
        @(posedge clk);
        #1;
        key_valid = 1'b0; auth_ok = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b0; auth_ok = 1'b0; key_code = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- reference model: fields as (value, digit count) pairs ----------------
    typedef enum int {P_ACC, P_PIN, P_AUTH, P_MENU, P_AMT, P_DEST, P_HOLD, P_LOCK} phase_t;
    phase_t ph;
    int fv[4], fn[4];
    int m_menu, m_op, m_age, m_idle, m_fail, m_cmd, m_err, m_locked;

    function automatic int lim_of(input int f);
        case (f)
            1:       return 9;
            2:       return 2047;
            default: return 4095;
        endcase
    endfunction

    function automatic int field_of(input phase_t p);
        case (p)
            P_PIN:   return 1;
            P_AMT:   return 2;
            P_DEST:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void model_logout();
        for (int i = 0; i < 4; i++) begin fv[i] = 0; fn[i] = 0; end
        ph = P_ACC; m_menu = 0; m_op = 0; m_age = 0; m_fail = 0;
    endfunction

    function automatic void model_hold();
        ph = P_HOLD; m_age = 0; m_menu = m_op; m_cmd = 1;
    endfunction

    function automatic void model_step(input int kv, input int code, input int auth);
        int f;
        bit quiet, tmo;
        m_cmd = 0; m_err = 0;
        quiet = (ph == P_LOCK) || (ph == P_ACC && fn[0] == 0);
        tmo = (kv == 0) && !quiet && (m_idle + 1 >= TMO);
        if (kv != 0 || tmo) m_idle = 0;
        else m_idle = (m_idle + 1 > TMO - 1) ? TMO - 1 : m_idle + 1;
        if (tmo || (kv != 0 && code == 12 && ph != P_LOCK)) begin
            model_logout();
            return;
        end
        case (ph)
            P_ACC, P_PIN, P_AMT, P_DEST: if (kv != 0) begin
                f = field_of(ph);
                if (code < 10) begin
                    if (fn[f] < (f == 1 ? 1 : 4) && fv[f] * 10 + code <= lim_of(f)) begin
                        fv[f] = fv[f] * 10 + code; fn[f]++;
                    end else m_err = 1;
                end else if (code == 10) begin
                    fv[f] = 0; fn[f] = 0;
                end else if (code == 11) begin
                    if (fn[f] == 0) m_err = 1;
                    else if (ph == P_ACC) ph = P_PIN;
                    else if (ph == P_PIN) begin ph = P_AUTH; m_age = 0; end
                    else if (ph == P_AMT && m_op == 6) ph = P_DEST;
                    else model_hold();
                end else m_err = 1;
            end
            P_AUTH: begin
                if (auth != 0) begin
                    ph = P_MENU; m_menu = 2; m_fail = 0;
                end else if (m_age == AW - 1) begin
                    ph = P_PIN; fv[1] = 0; fn[1] = 0; m_err = 1;
`ifdef ATM_PIN_LOCKOUT_EN
                    m_fail++;
                    if (m_fail == 3) begin ph = P_LOCK; m_locked = 1; m_menu = 0; end
`endif
                end else m_age++;
            end
            P_MENU: if (kv != 0) begin
                if (code >= 3 && code <= 7) begin
                    m_op = code; fv[2] = 0; fn[2] = 0; fv[3] = 0; fn[3] = 0;
                    if (code == 3) model_hold(); else ph = P_AMT;
                end else if (code == 10) begin
                    fv[2] = 0; fn[2] = 0; fv[3] = 0; fn[3] = 0;
                end else m_err = 1;
            end
            P_HOLD: begin
                if (m_age == HC - 1) begin ph = P_MENU; m_menu = 2; end
                else m_age++;
            end
            default: ;
        endcase
    endfunction

    function automatic void build_table();
        v(1,4,0, 4,0,0,0,0,0,0);      v(1,0,0, 40,0,0,0,0,0,0);
        v(1,2,0, 402,0,0,0,0,0,0);    v(1,3,0, 4023,0,0,0,0,0,0);
        v(1,11,0, 4023,0,0,0,0,0,0);  v(1,0,0, 4023,0,0,0,0,0,0);
        v(1,11,0, 4023,0,0,0,0,0,0);  v(0,0,1, 4023,0,2,0,0,0,0);
        v(1,4,0, 4023,0,2,0,0,0,0);   v(1,1,0, 4023,0,2,1,0,0,0);
        v(1,5,0, 4023,0,2,15,0,0,0);  v(1,0,0, 4023,0,2,150,0,0,0);
        v(1,11,0, 4023,0,4,150,0,1,0);
        for (int i = 0; i < 3; i++) v(0,0,0, 4023,0,4,150,0,0,0);
        v(0,0,0, 4023,0,2,150,0,0,0);
        v(1,5,0, 4023,0,2,0,0,0,0);   v(1,2,0, 4023,0,2,2,0,0,0);
        v(1,0,0, 4023,0,2,20,0,0,0);  v(1,4,0, 4023,0,2,204,0,0,0);
        v(1,8,0, 4023,0,2,204,0,0,1); v(1,10,0, 4023,0,2,0,0,0,0);
        v(1,2,0, 4023,0,2,2,0,0,0);   v(1,0,0, 4023,0,2,20,0,0,0);
        v(1,4,0, 4023,0,2,204,0,0,0); v(1,7,0, 4023,0,2,2047,0,0,0);
        v(1,11,0, 4023,0,5,2047,0,1,0);
        for (int i = 0; i < 3; i++) v(0,0,0, 4023,0,5,2047,0,0,0);
        v(0,0,0, 4023,0,2,2047,0,0,0);
        v(1,6,0, 4023,0,2,0,0,0,0);   v(1,5,0, 4023,0,2,5,0,0,0);
        v(1,0,0, 4023,0,2,50,0,0,0);  v(1,11,0, 4023,0,2,50,0,0,0);
        v(1,1,0, 4023,0,2,50,1,0,0);  v(1,3,0, 4023,0,2,50,13,0,0);
        v(1,9,0, 4023,0,2,50,139,0,0); v(1,2,0, 4023,0,2,50,1392,0,0);
        v(1,11,0, 4023,0,6,50,1392,1,0);
        for (int i = 0; i < 3; i++) v(0,0,0, 4023,0,6,50,1392,0,0);
        v(0,0,0, 4023,0,2,50,1392,0,0);
        v(1,2,0, 4023,0,2,50,1392,0,1);  v(1,14,0, 4023,0,2,50,1392,0,1);
        v(1,7,0, 4023,0,2,0,0,0,0);      v(1,11,0, 4023,0,2,0,0,0,1);
        v(1,9,0, 4023,0,2,9,0,0,0);      v(1,12,0, 0,0,0,0,0,0,0);
        v(1,4,0, 4,0,0,0,0,0,0);       v(1,0,0, 40,0,0,0,0,0,0);
        v(1,9,0, 409,0,0,0,0,0,0);     v(1,6,0, 409,0,0,0,0,0,1);
        v(1,5,0, 4095,0,0,0,0,0,0);    v(1,1,0, 4095,0,0,0,0,0,1);
        v(1,11,0, 4095,0,0,0,0,0,0);   v(1,7,0, 4095,7,0,0,0,0,0);
        v(1,3,0, 4095,7,0,0,0,0,1);    v(1,11,0, 4095,7,0,0,0,0,0);
        v(0,0,0, 4095,7,0,0,0,0,0);    v(1,5,0, 4095,7,0,0,0,0,0);
        for (int i = 0; i < 5; i++) v(0,0,0, 4095,7,0,0,0,0,0);
        v(0,0,0, 4095,0,0,0,0,0,1);    v(1,11,0, 4095,0,0,0,0,0,1);
        v(1,13,0, 4095,0,0,0,0,0,1);
    endfunction

    initial begin
        int kv, code, au, r;
        build_table();
        do_reset();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.locked", int'(locked), 0);

        foreach (tbl[i]) begin
            step(tbl[i].kv, tbl[i].code, tbl[i].auth);
            check_all($sformatf("vec%0d", i), tbl[i].acc, tbl[i].pin, tbl[i].menu,
                      tbl[i].amt, tbl[i].dest, tbl[i].cmd, tbl[i].err);
        end

        // reset in the middle of PIN entry discards everything
        do_reset();
        check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);

        model_logout(); m_idle = 0; m_locked = 0;
        for (int n = 0; n < 3000; n++) begin
            kv = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r  = $urandom_range(0, 99);
            if (r < 60)      code = $urandom_range(0, 9);
            else if (r < 85) code = 11;
            else if (r < 93) code = 10;
            else if (r < 96) code = 12;
            else             code = $urandom_range(13, 15);
            au = ($urandom_range(0, 3) == 0) ? 1 : 0;
            step(kv, code, au);
            model_step(kv, code, au);
            check_all($sformatf("rnd%0d", n), fv[0], fv[1], m_menu, fv[2], fv[3], m_cmd, m_err);
            chk($sformatf("rnd%0d.locked", n), int'(locked), m_locked);
        end

        // inactivity logout from MENU after exactly TMO keyless cycles
        do_reset();
        step(1, 1, 0); step(1, 11, 0); step(1, 5, 0); step(1, 11, 0); step(0, 0, 1);
        check_all("tmo_menu", 1, 5, 2, 0, 0, 0, 0);
        repeat (TMO - 2) step(0, 0, 0);
        check_all("tmo_before", 1, 5, 2, 0, 0, 0, 0);
        step(0, 0, 0);
        check_all("tmo_after", 0, 0, 0, 0, 0, 0, 0);

        // three consecutive authentication failures
        do_reset();
        step(1, 1, 0); step(1, 11, 0);
        for (int a = 0; a < 3; a++) begin
            step(1, 5, 0); step(1, 11, 0);
            repeat (AW) step(0, 0, 0);
        end
`ifdef ATM_PIN_LOCKOUT_EN
        chk("lock.locked", int'(locked), 1);
        chk("lock.menu", int'(menuOption), 0);
        step(1, 12, 0);
        chk("lock_cancel.locked", int'(locked), 1);
        chk("lock_cancel.acc", int'(accNumber), 1);
        step(1, 3, 0);
        chk("lock_key.pin", int'(pin), 0);
        chk("lock_key.err", int'(entry_error), 0);
        do_reset();
        chk("lock_rst.locked", int'(locked), 0);
`else
        chk("nolock.locked", int'(locked), 0);
        chk("nolock.pin", int'(pin), 0);
        step(1, 5, 0);
        chk("nolock_retry.pin", int'(pin), 5);
        chk("nolock_retry.acc", int'(accNumber), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
